opl3_host_wr_fifo: RTL

//  Host-side register-write front end; sits directly upstream of the register file.

---
 rtl/opl3_host_wr_fifo_if.sv | 32 +++
 rtl/opl3_host_wr_fifo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/opl3_host_wr_fifo_if.sv
// ---------------------------------------------------------------------------
// opl3_host_wr_fifo_if
//   Host-side bus of the OPL3 register-write front end.
//   Ports (signals):
//     host_wr     host write strobe, one byte per cycle when high
//     host_a      {A1,A0}: A1 = bank, A0 = 0 address port / 1 data port
//     host_din    host write byte
//     host_full   FIFO full; data-port writes are dropped while high
//     host_ovf    sticky overflow flag, cleared only by reset
//     fifo_level  current FIFO occupancy (0..FIFO_DEPTH)
//   Modports: master = host side, slave = FIFO side.
// ---------------------------------------------------------------------------
interface opl3_host_wr_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          host_wr;
  logic [1:0]                    host_a;
  logic [7:0]                    host_din;
  logic                          host_full;
  logic                          host_ovf;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  modport master (
    output host_wr, host_a, host_din,
    input  host_full, host_ovf, fifo_level
  );

  modport slave (
    input  host_wr, host_a, host_din,
    output host_full, host_ovf, fifo_level
  );
endinterface

// File: rtl/opl3_host_wr_fifo.sv
// ---------------------------------------------------------------------------
// opl3_pkg / opl3_host_wr_fifo
//   Host-side register-write front end, directly upstream of the register
//   file. Emulates the OPL3 address/data port pair per bank, buffers complete
//   {bank,address,data} writes in a FIFO and drains them as single-cycle
//   opl3_reg_wr pulses.
//   Ports:
//     clk          system clock (opl3_pkg::CLK_FREQ), single domain
//     ic_n         synchronous active-low reset
//     host         opl3_host_wr_fifo_if.slave host bus
//     opl3_reg_wr  {valid,bank_num,address,data} register-write pulse
//   Configuration macro: OPL3_WR_PACING_EN
//     defined   -> successive pulses spaced at least WR_SPACING cycles
//     undefined -> pacing logic not built, one pop per cycle
// ---------------------------------------------------------------------------
package opl3_pkg;
  localparam int CLK_FREQ = 14_318_180;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;
endpackage

module opl3_host_wr_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WR_SPACING = 32
) (
  input  logic                    clk,
  input  logic                    ic_n,
  opl3_host_wr_fifo_if.slave      host,
  output opl3_pkg::opl3_reg_wr_t  opl3_reg_wr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_next;
  logic [7:0]      addr_q;
  logic            full_q;
  logic            ovf_q;
  logic            full;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            pace_ok;

  // Bank comes from A1 of the data write itself, so only the address byte
  // needs latching between the two port writes.
  assign full     = (level == LW'(FIFO_DEPTH));
  assign push_req = host.host_wr & host.host_a[0];
  assign push     = push_req & ~full;
  assign pop      = (level != '0) & pace_ok;

`ifdef OPL3_WR_PACING_EN
  localparam int PW = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;
  logic [PW-1:0] pace_cnt;

  // Loaded on each issue, counts down to zero and stays there.
  always_ff @(posedge clk) begin
    if (!ic_n) begin
      pace_cnt <= '0;
    end else if (pop) begin
      pace_cnt <= PW'(WR_SPACING - 1);
    end else if (pace_cnt != '0) begin
      pace_cnt <= pace_cnt - 1'b1;
    end
  end

  assign pace_ok = (pace_cnt == '0);
`else
  assign pace_ok = 1'b1;
`endif

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (!push && pop) begin
      level_next = level - 1'b1;
    end
  end

  // NOTE: storage array has no reset; resetting the pointers and level is
  // what discards its contents, and it lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{bank_num: host.host_a[1], address: addr_q, data: host.host_din};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!ic_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      addr_q      <= 8'h00;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      opl3_reg_wr <= '0;
    end else begin
      if (host.host_wr && !host.host_a[0]) begin
        addr_q <= host.host_din;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // A push into a full FIFO is lost even if a pop frees a slot this cycle.
      if (push_req && full) begin
        ovf_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        opl3_reg_wr <= {1'b1, mem[rd_ptr]};
      end else begin
        opl3_reg_wr.valid <= 1'b0;
      end
      level  <= level_next;
      // Tracks level_next, so host_full always equals (level == FIFO_DEPTH).
      full_q <= (level_next == LW'(FIFO_DEPTH));
    end
  end

  assign host.host_full  = full_q;
  assign host.host_ovf   = ovf_q;
  assign host.fifo_level = level;

endmodule
